jacobi_eig_sorter: RTL and testbench
====================================

JACOBI_EIG_SORTER -- requirements
Module: jacobi_eig_sorter

Interface
REQ-001 Parameter N, default 8: eigenvalues per frame (matrix dimension); N >= 2.
REQ-002 Parameter W, default JACOBI_OUTPUT_WORD_WIDTH: signed fixed-point word width.
REQ-003 Derived localparam IW = $clog2(N): index width.
REQ-004 Port clk  input  1: single clock; all logic on its rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port in_dat_i  input  W: eigenvalue word from the Jacobi core output stream.
REQ-007 Port in_vld_i  input  1: in_dat_i valid.
REQ-008 Port in_rdy_o  output  1: block accepts in_dat_i this cycle.
REQ-009 Port out_dat_o  output  OW: sorted word; OW = W+IW with JACOBI_SORT_INDEX_EN, else W.
REQ-010 Port out_vld_o  output  1: out_dat_o valid.
REQ-011 Port out_rdy_i  input  1: downstream accepts out_dat_o.
REQ-012 Port out_last_o  output  1: high with the Nth (final) word of a sorted frame.

Function
REQ-013 Transfer SHALL occur on a side only when vld and rdy are both high at a rising edge.
REQ-014 Two states: FILL (in_rdy_o=1, out_vld_o=0) and DRAIN (in_rdy_o=0, out_vld_o=1).
REQ-015 In FILL, each accepted word SHALL be inserted in one cycle into an N-slot register array kept sorted descending (signed compare), tagged with arrival index 0..N-1.
REQ-016 Ties: an equal value SHALL be placed after previously stored equal values (stable sort).
REQ-017 Fill counter counts accepts; on the Nth accept the state SHALL become DRAIN on the next edge.
REQ-018 out_vld_o SHALL assert the cycle after the Nth input accept (latency 1 from last input).
REQ-019 out_dat_o SHALL be driven from array slot 0 (registered); each output handshake shifts the array up one slot.
REQ-020 out_dat_o and out_vld_o SHALL hold stable while out_vld_o=1 and out_rdy_i=0.
REQ-021 out_last_o SHALL be high exactly while the Nth word of the frame is presented.
REQ-022 After the Nth output handshake the state SHALL return to FILL on the next edge; in_rdy_o high that cycle; counters cleared.
REQ-023 No input accepted during DRAIN; no output presented during FILL (no frame overlap).
REQ-024 Sort is bit-exact: no arithmetic on data words, only compare and move.

Reset
REQ-025 rst SHALL force FILL, counters to 0, in_rdy_o=1 on the edge after assertion... held while rst high.
REQ-026 During rst: out_vld_o=0, out_last_o=0, out_dat_o=0; array contents cleared to 0.
REQ-027 rst mid-fill or mid-drain SHALL discard the partial frame; next accepted word is index 0.

Configuration
REQ-028 Macro JACOBI_SORT_INDEX_EN defined: out_dat_o = {index[IW-1:0], value[W-1:0]}, index = original arrival position.
REQ-029 Macro undefined: index storage not instantiated; out_dat_o = value only (OW=W); ordering identical.

Structure
REQ-030 Package common SHALL hold JACOBI_N and JACOBI_SORT_IDX_WIDTH constants and a typedef for the {index,value} slot record.
REQ-031 One sub-module jacobi_sort_cell: one slot with compare, hold/load/shift-from-above/shift-from-below; N instances chained.

Verification
REQ-032 N=4, inputs 3,-1,7,2, out_rdy_i=1 -> outputs 7,3,2,-1; indices 2,0,3,1; out_last_o on -1; out_vld_o one cycle after 4th accept.
REQ-033 N=4, inputs 5,5,1,5 -> outputs 5,5,5,1 with indices 0,1,3,2 (stable).
REQ-034 Output backpressure: out_rdy_i=0 for 5 cycles mid-drain -> out_dat_o constant, in_rdy_o=0, no word lost or duplicated.
REQ-035 Extreme values: inputs 0x7FFFFFFF, 0x80000000, 0, -1 (W=32) -> 0x7FFFFFFF, 0, -1, 0x80000000.
REQ-036 rst asserted after 2 of 4 inputs, then new frame 1,2,3,4 -> outputs 4,3,2,1, indices 3,2,1,0.
REQ-037 Back-to-back frames with in_vld_i held high -> in_rdy_o low exactly during drain; second frame sorted independently; repeat with macro undefined, OW=W.

Source files
------------

// File: rtl/jacobi_eig_sorter_pkg.sv
// Shared constants and slot record for the Jacobi eigenvalue sorter.
// The optional index tagging is controlled by the JACOBI_SORT_INDEX_EN macro.
package jacobi_eig_sorter_pkg;

    localparam int JACOBI_OUTPUT_WORD_WIDTH = 32;
    localparam int JACOBI_N                 = 8;
    localparam int JACOBI_SORT_IDX_WIDTH    = $clog2(JACOBI_N);

    // One sorter slot at default sizing: arrival index above the value word
    typedef struct packed {
        logic [JACOBI_SORT_IDX_WIDTH-1:0]    idx;
        logic [JACOBI_OUTPUT_WORD_WIDTH-1:0] val;
    } jacobi_slot_t;

endpackage

// File: rtl/jacobi_sort_cell.sv
// One slot of the insertion-sort register chain.
// Hold / load new word / shift from the slot above (insert) / shift from below (drain).
// Index storage exists only when JACOBI_SORT_INDEX_EN is defined.
module jacobi_sort_cell #(
    parameter int W = 32
`ifdef JACOBI_SORT_INDEX_EN
    , parameter int IW = 3
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_ins,      // insert cycle
    input  logic         i_shf,      // drain shift cycle
    input  logic         i_occ,      // slot currently holds a frame word
    input  logic [W-1:0] i_din_val,
    input  logic [W-1:0] i_up_val,
    input  logic         i_up_ge,    // slot above keeps its word (or this is slot 0)
    input  logic [W-1:0] i_dn_val,
`ifdef JACOBI_SORT_INDEX_EN
    input  logic [IW-1:0] i_din_idx,
    input  logic [IW-1:0] i_up_idx,
    input  logic [IW-1:0] i_dn_idx,
    output logic [IW-1:0] o_idx,
`endif
    output logic [W-1:0] o_val,
    output logic         o_ge
);

    logic [W-1:0] r_val;

    // Stored word stays ahead of an equal newcomer, which keeps the sort stable
    assign o_ge  = i_occ && ($signed(r_val) >= $signed(i_din_val));
    assign o_val = r_val;

    // Value slot update
    always_ff @(posedge clk) begin
        if (rst)                 r_val <= '0;
        else if (i_shf)          r_val <= i_dn_val;
        else if (i_ins && !o_ge) r_val <= i_up_ge ? i_din_val : i_up_val;
    end

`ifdef JACOBI_SORT_INDEX_EN
    logic [IW-1:0] r_idx;
    assign o_idx = r_idx;

    // Index slot follows the value slot move for move
    always_ff @(posedge clk) begin
        if (rst)                 r_idx <= '0;
        else if (i_shf)          r_idx <= i_dn_idx;
        else if (i_ins && !o_ge) r_idx <= i_up_ge ? i_din_idx : i_up_idx;
    end
`endif

endmodule

// File: rtl/jacobi_eig_sorter.sv
// Frame sorter for Jacobi eigenvalues: fills N words into a descending,
// stable, signed insertion-sort chain, then drains them largest first.
// Define JACOBI_SORT_INDEX_EN to append the arrival index above each output word.
module jacobi_eig_sorter
    import jacobi_eig_sorter_pkg::*;
#(
    parameter  int N  = JACOBI_N,
    parameter  int W  = JACOBI_OUTPUT_WORD_WIDTH,
    localparam int IW = $clog2(N),
`ifdef JACOBI_SORT_INDEX_EN
    localparam int OW = W + IW
`else
    localparam int OW = W
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_dat_i,
    input  logic          in_vld_i,
    output logic          in_rdy_o,
    output logic [OW-1:0] out_dat_o,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic          out_last_o
);

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t        r_state, w_nxt;
    logic [IW-1:0] r_cnt;
    logic          w_acc, w_hs, w_last;

    logic [N-1:0][W-1:0] w_val, w_up_val, w_dn_val;
    logic [N-1:0]        w_ge, w_up_ge, w_occ;
`ifdef JACOBI_SORT_INDEX_EN
    logic [N-1:0][IW-1:0] w_idx, w_up_idx, w_dn_idx;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FILL;
        else     r_state <= w_nxt;
    end

    // Next state and handshake decode
    always_comb begin
        w_nxt    = r_state;
        in_rdy_o = 1'b0;
        w_acc    = 1'b0;
        w_hs     = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            S_FILL: begin
                in_rdy_o = 1'b1;
                w_acc    = in_vld_i;
                if (w_acc && r_cnt == LAST) w_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_last = (r_cnt == LAST);
                w_hs   = out_rdy_i;
                if (w_hs && w_last) w_nxt = S_FILL;
            end
            default: w_nxt = S_FILL;
        endcase
    end

    // Shared counter: arrival index while filling, output position while draining
    always_ff @(posedge clk) begin
        if (rst)                r_cnt <= '0;
        else if (w_acc || w_hs) r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + IW'(1);
    end

    // Sort chain: slot 0 holds the largest word
    for (genvar g = 0; g < N; g++) begin : g_cell
        assign w_occ[g] = (r_cnt > IW'(g));

        if (g == 0) begin : g_top
            assign w_up_val[g] = '0;
            assign w_up_ge[g]  = 1'b1;
`ifdef JACOBI_SORT_INDEX_EN
            assign w_up_idx[g] = '0;
`endif
        end else begin : g_mid
            assign w_up_val[g] = w_val[g-1];
            assign w_up_ge[g]  = w_ge[g-1];
`ifdef JACOBI_SORT_INDEX_EN
            assign w_up_idx[g] = w_idx[g-1];
`endif
        end

        if (g == N - 1) begin : g_bot
            assign w_dn_val[g] = '0;
`ifdef JACOBI_SORT_INDEX_EN
            assign w_dn_idx[g] = '0;
`endif
        end else begin : g_nbot
            assign w_dn_val[g] = w_val[g+1];
`ifdef JACOBI_SORT_INDEX_EN
            assign w_dn_idx[g] = w_idx[g+1];
`endif
        end

        jacobi_sort_cell #(
            .W  (W)
`ifdef JACOBI_SORT_INDEX_EN
            , .IW (IW)
`endif
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .i_ins     (w_acc),
            .i_shf     (w_hs),
            .i_occ     (w_occ[g]),
            .i_din_val (in_dat_i),
            .i_up_val  (w_up_val[g]),
            .i_up_ge   (w_up_ge[g]),
            .i_dn_val  (w_dn_val[g]),
`ifdef JACOBI_SORT_INDEX_EN
            .i_din_idx (r_cnt),
            .i_up_idx  (w_up_idx[g]),
            .i_dn_idx  (w_dn_idx[g]),
            .o_idx     (w_idx[g]),
`endif
            .o_val     (w_val[g]),
            .o_ge      (w_ge[g])
        );
    end

    // Outputs come straight from the state register and slot 0; forced quiet in reset
    assign out_vld_o  = (r_state == S_DRAIN) && !rst;
    assign out_last_o = w_last && !rst;
`ifdef JACOBI_SORT_INDEX_EN
    assign out_dat_o  = rst ? '0 : {w_idx[0], w_val[0]};
`else
    assign out_dat_o  = rst ? '0 : w_val[0];
`endif

endmodule

// File: tb/tb_jacobi_eig_sorter.sv
// Scoreboard bench for jacobi_eig_sorter at N=4, W=32; works with or without JACOBI_SORT_INDEX_EN.
module tb_jacobi_eig_sorter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;
`ifdef JACOBI_SORT_INDEX_EN
    localparam int OW = W + IW;
`else
    localparam int OW = W;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_dat_i;
    logic          in_vld_i;
    logic          in_rdy_o;
    logic [OW-1:0] out_dat_o;
    logic          out_vld_o;
    logic          out_rdy_i;
    logic          out_last_o;

    jacobi_eig_sorter #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_dat_i   (in_dat_i),
        .in_vld_i   (in_vld_i),
        .in_rdy_o   (in_rdy_o),
        .out_dat_o  (out_dat_o),
        .out_vld_o  (out_vld_o),
        .out_rdy_i  (out_rdy_i),
        .out_last_o (out_last_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] dat;
        logic          last;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] v, input logic [IW-1:0] idx, input logic last);
        exp_t e;
        e.dat  = OW'({idx, v});
        e.last = last;
        q.push_back(e);
    endtask

    // Push one word; leaves in_vld_i high so frames can run back to back
    task automatic send(input logic [W-1:0] v);
        bit got = 0;
        in_dat_i = v;
        in_vld_i = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (in_rdy_o) got = 1;
            @(posedge clk);
            #1;
        end
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300 && q.size() > 0; k++) @(posedge clk);
        chk("drain_timeout", 64'(q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    // Reference handshake model: expected FILL/DRAIN phase
    int acc_m = 0, out_m = 0;
    bit exp_drain = 0;
    always @(posedge clk) begin
        if (rst) begin
            acc_m <= 0; out_m <= 0; exp_drain <= 0;
        end else begin
            if (in_vld_i && in_rdy_o) begin
                if (acc_m == N - 1) begin acc_m <= 0; exp_drain <= 1; end
                else acc_m <= acc_m + 1;
            end
            if (out_vld_o && out_rdy_i) begin
                if (out_m == N - 1) begin out_m <= 0; exp_drain <= 0; end
                else out_m <= out_m + 1;
            end
        end
    end

    // Monitor: phase, hold-under-backpressure, and scoreboard compare
    bit            hold_prev = 0;
    logic [OW-1:0] prev_dat;
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            chk("out_vld", 64'(out_vld_o), 64'(exp_drain));
            chk("in_rdy", 64'(in_rdy_o), 64'(!exp_drain));
            if (hold_prev) chk("hold_dat", 64'(out_dat_o), 64'(prev_dat));
            if (out_vld_o && out_rdy_i) begin
                if (q.size() == 0) chk("unexpected_out", 64'(out_dat_o), 0);
                else begin
                    e = q.pop_front();
                    chk("out_dat", 64'(out_dat_o), 64'(e.dat));
                    chk("out_last", 64'(out_last_o), 64'(e.last));
                end
            end else if (!out_vld_o) begin
                chk("last_idle", 64'(out_last_o), 0);
            end
            hold_prev <= out_vld_o && !out_rdy_i;
            prev_dat  <= out_dat_o;
        end else begin
            hold_prev <= 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_vld_i = 1'b0; in_dat_i = '0; out_rdy_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 64'(out_vld_o), 0);
        chk("rst_last", 64'(out_last_o), 0);
        chk("rst_dat", 64'(out_dat_o), 0);
        chk("rst_rdy", 64'(in_rdy_o), 1);
        @(posedge clk); #1 rst = 1'b0;

        // Basic ordering with indices
        push(32'd7, 2, 0); push(32'd3, 0, 0); push(32'd2, 3, 0); push(-32'sd1, 1, 1);
        send(32'd3); send(-32'sd1); send(32'd7); send(32'd2);
        in_vld_i = 1'b0;
        wait_drain();

        // Ties stay in arrival order
        push(32'd5, 0, 0); push(32'd5, 1, 0); push(32'd5, 3, 0); push(32'd1, 2, 1);
        send(32'd5); send(32'd5); send(32'd1); send(32'd5);
        in_vld_i = 1'b0;
        wait_drain();

        // Backpressure for 5 cycles after the first output word
        push(32'd40, 1, 0); push(32'd30, 3, 0); push(32'd20, 2, 0); push(32'd10, 0, 1);
        send(32'd10); send(32'd40); send(32'd20); send(32'd30);
        in_vld_i = 1'b0;
        @(posedge clk); #1 out_rdy_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_rdy_i = 1'b1;
        wait_drain();

        // Signed extremes
        push(32'h7FFFFFFF, 0, 0); push(32'h0, 2, 0); push(32'hFFFFFFFF, 3, 0); push(32'h80000000, 1, 1);
        send(32'h7FFFFFFF); send(32'h80000000); send(32'h0); send(32'hFFFFFFFF);
        in_vld_i = 1'b0;
        wait_drain();

        // Reset mid-fill discards the partial frame
        send(32'd9); send(32'd8);
        in_vld_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push(32'd4, 3, 0); push(32'd3, 2, 0); push(32'd2, 1, 0); push(32'd1, 0, 1);
        send(32'd1); send(32'd2); send(32'd3); send(32'd4);
        in_vld_i = 1'b0;
        wait_drain();

        // Back-to-back frames with in_vld_i held high
        push(32'd12, 3, 0); push(32'd6, 0, 0); push(32'd0, 2, 0); push(-32'sd6, 1, 1);
        push(-32'sd2, 3, 0); push(-32'sd3, 0, 0); push(-32'sd3, 1, 0); push(-32'sd9, 2, 1);
        send(32'd6); send(-32'sd6); send(32'd0); send(32'd12);
        send(-32'sd3); send(-32'sd3); send(-32'sd9); send(-32'sd2);
        in_vld_i = 1'b0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
